// File: rtl/serve_speed_ctrl.sv
// Pong game timebase: ball/paddle prescalers gated by SERVE/RUN/PAUSE,
// with ball speed stepping up every few paddle hits and resetting on each point.
module serve_speed_ctrl #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned BASE_PERIOD   = 32'h7fff,
  parameter int unsigned STEP          = 32'h0800,
  parameter int unsigned MAXLVL        = 7,
  parameter int unsigned HITS_PER_LVL  = 4,
  parameter int unsigned SERVE_TICKS   = 32,
  parameter int unsigned PADDLE_PERIOD = 32'h3fff
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hit,
  input  logic       point,
  input  logic       pause,
  output logic       ball_tick,
  output logic       paddle_tick,
  output logic [2:0] level,
  output logic       serving
);

  localparam int unsigned HW = (HITS_PER_LVL > 1) ? $clog2(HITS_PER_LVL) : 1;
  localparam int unsigned SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] ball_cnt;
  logic [WIDTH-1:0] paddle_cnt;
  logic [WIDTH-1:0] cur_period;
  logic [SW-1:0]    serve_cnt;
  logic [HW-1:0]    hit_cnt;

  logic ball_wrap;
  logic paddle_wrap;

  assign ball_wrap   = (ball_cnt == cur_period - WIDTH'(1));
  assign paddle_wrap = (paddle_cnt == WIDTH'(PADDLE_PERIOD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SERVE;
      ball_cnt    <= '0;
      paddle_cnt  <= '0;
      cur_period  <= WIDTH'(BASE_PERIOD);
      serve_cnt   <= '0;
      hit_cnt     <= '0;
      level       <= '0;
      ball_tick   <= 1'b0;
      paddle_tick <= 1'b0;
      serving     <= 1'b1;
    end else begin
      ball_tick   <= 1'b0;
      paddle_tick <= 1'b0;

      // Paddle timebase only freezes on pause; game state never restarts it.
      if (!pause) begin
        if (paddle_wrap) begin
          paddle_cnt  <= '0;
          paddle_tick <= 1'b1;
        end else begin
          paddle_cnt <= paddle_cnt + WIDTH'(1);
        end
      end

      if (point) begin
        state      <= SERVE;
        serving    <= 1'b1;
        level      <= '0;
        hit_cnt    <= '0;
        serve_cnt  <= '0;
        ball_cnt   <= '0;
        cur_period <= WIDTH'(BASE_PERIOD);
      end else begin
        // New period takes effect only at a wrap so a running count is never cut short.
        if (!pause) begin
          if (ball_wrap) begin
            ball_cnt   <= '0;
            cur_period <= WIDTH'(BASE_PERIOD) - WIDTH'(level) * WIDTH'(STEP);
            if (state != SERVE) ball_tick <= 1'b1;
          end else begin
            ball_cnt <= ball_cnt + WIDTH'(1);
          end
        end

        case (state)
          SERVE: begin
            if (!pause && ball_wrap) begin
              if (serve_cnt == SW'(SERVE_TICKS - 1)) begin
                state     <= RUN;
                serving   <= 1'b0;
                serve_cnt <= '0;
              end else begin
                serve_cnt <= serve_cnt + SW'(1);
              end
            end
          end
          RUN: begin
            if (pause) begin
              state <= PAUSE;
            end else if (hit) begin
              if (hit_cnt == HW'(HITS_PER_LVL - 1)) begin
                hit_cnt <= '0;
                if (level != 3'(MAXLVL)) level <= level + 3'd1;
              end else begin
                hit_cnt <= hit_cnt + HW'(1);
              end
            end
          end
          PAUSE: begin
            if (!pause) state <= RUN;
          end
          default: state <= SERVE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serve_speed_ctrl.sv
// Directed bench for serve_speed_ctrl: expected tick cycles are queued by the
// stimulus process and a negedge monitor pops and compares them as ticks appear.
module tb_serve_speed_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hit = 1'b0;
  logic       point = 1'b0;
  logic       pause = 1'b0;
  logic       ball_tick;
  logic       paddle_tick;
  logic [2:0] level;
  logic       serving;

  int checks = 0;
  int failures = 0;
  int cyc;
  int ball_q[$];
  int paddle_q[$];
  bit paddle_on = 1'b1;
  int paddle_seen = 0;
  int p0;

  serve_speed_ctrl #(
    .WIDTH(16), .BASE_PERIOD(20), .STEP(2), .MAXLVL(3),
    .HITS_PER_LVL(2), .SERVE_TICKS(3), .PADDLE_PERIOD(5)
  ) dut (
    .clk(clk), .reset(reset), .hit(hit), .point(point), .pause(pause),
    .ball_tick(ball_tick), .paddle_tick(paddle_tick), .level(level), .serving(serving)
  );

  always #5 clk = ~clk;

  // Edge index since reset release; value k is visible at the negedge after edge k.
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ball_tick) begin
        if (ball_q.size() == 0) check("ball_tick_unexpected", cyc, -1);
        else                    check("ball_tick_cycle", cyc, ball_q.pop_front());
      end
      if (paddle_tick) begin
        paddle_seen++;
        if (paddle_on) begin
          if (paddle_q.size() == 0) check("paddle_tick_unexpected", cyc, -1);
          else                      check("paddle_tick_cycle", cyc, paddle_q.pop_front());
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic hit_at(input int e);
    wait_cyc(e - 1);
    hit = 1'b1;
    wait_cyc(e);
    hit = 1'b0;
  endtask

  task automatic point_at(input int e);
    wait_cyc(e - 1);
    point = 1'b1;
    wait_cyc(e);
    point = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int t = 5; t <= 120; t += 5) paddle_q.push_back(t);
    ball_q.push_back(80);  ball_q.push_back(100); ball_q.push_back(120);
    ball_q.push_back(140); ball_q.push_back(158); ball_q.push_back(172);
    ball_q.push_back(186);

    #21;
    check("reset_serving", int'(serving), 1);
    check("reset_level", int'(level), 0);
    check("reset_ball_tick", int'(ball_tick), 0);
    check("reset_paddle_tick", int'(paddle_tick), 0);
    #1 reset = 1'b0;

    // Serve lasts three base periods, then play starts.
    wait_cyc(59); check("serve1_serving_before_end", int'(serving), 1);
    wait_cyc(60); check("serve1_serving_after_end", int'(serving), 0);
    wait_cyc(121); paddle_on = 1'b0;

    // Two hits raise one level; further hits saturate at 3.
    hit_at(126); check("lvl_before_2nd_hit", int'(level), 0);
    hit_at(127); check("lvl_after_2_hits", int'(level), 1);
    for (int e = 141; e <= 146; e++) hit_at(e);
    check("lvl_saturated", int'(level), 3);
    wait_cyc(147); check("lvl_saturated_hold", int'(level), 3);

    point_at(190);
    check("point_serving", int'(serving), 1);
    check("point_level", int'(level), 0);
    ball_q.push_back(270); ball_q.push_back(290); ball_q.push_back(410);
    wait_cyc(249); check("serve2_serving_before_end", int'(serving), 1);
    wait_cyc(250); check("serve2_serving_after_end", int'(serving), 0);

    // Pause with ball_cnt at 7 for 100 cycles.
    wait_cyc(297); pause = 1'b1;
    wait_cyc(298); p0 = paddle_seen;
    wait_cyc(397); check("paddle_frozen_in_pause", paddle_seen - p0, 0);
    pause = 1'b0;
    wait_cyc(411); check("lvl_after_pause", int'(level), 0);

    for (int e = 412; e <= 415; e++) hit_at(e);
    check("lvl_after_4_hits", int'(level), 2);
    hit_at(420);

    // Hit and point together: point wins, the hit is dropped.
    wait_cyc(424); hit = 1'b1; point = 1'b1;
    wait_cyc(425); hit = 1'b0; point = 1'b0;
    check("hitpoint_level", int'(level), 0);
    check("hitpoint_serving", int'(serving), 1);
    wait_cyc(426); check("hitpoint_level_hold", int'(level), 0);
    ball_q.push_back(505); ball_q.push_back(525);
    wait_cyc(484); check("serve3_serving_before_end", int'(serving), 1);
    wait_cyc(485); check("serve3_serving_after_end", int'(serving), 0);

    // Pause during serve stretches it by the pause length (25 cycles).
    point_at(530);
    wait_cyc(539); pause = 1'b1;
    wait_cyc(560); check("serve_pause_serving", int'(serving), 1);
    wait_cyc(564); pause = 1'b0;
    ball_q.push_back(635);
    wait_cyc(614); check("serve4_serving_before_end", int'(serving), 1);
    wait_cyc(615); check("serve4_serving_after_end", int'(serving), 0);

    for (int e = 620; e <= 623; e++) hit_at(e);
    check("lvl_before_reset", int'(level), 2);

    // Asynchronous reset between edges while ball_tick is high.
    wait_cyc(635);
    #2 reset = 1'b1;
    #1;
    check("async_reset_level", int'(level), 0);
    check("async_reset_serving", int'(serving), 1);
    check("async_reset_ball_tick", int'(ball_tick), 0);
    check("async_reset_paddle_tick", int'(paddle_tick), 0);
    check("ball_ticks_missing", ball_q.size(), 0);
    check("paddle_ticks_missing", paddle_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
